// File: rtl/strobe_pkg.sv
// Shared types and widths for the strobe checker.
// No logic: FSM state encoding and the interval/wcnt width only.
// No flow control.
package strobe_pkg;

    // Width of the interval input and of the marker-word counter
    localparam int STRB_IW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        VERIFY = 2'd2,
        LOCKED = 2'd3
    } strb_state_e;

endpackage

// File: rtl/strobe_chk_w_delay_level_delay.sv
// Level delay: output follows a rising input level after delay_i cycles.
// Latency: delay_i clk cycles on the rising edge; a falling input clears the output in the same cycle.
// No backpressure; pure level-in/level-out.
module level_delay #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         level_i,
    input  logic [W-1:0] delay_i,
    output logic         level_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Count cycles the input has been high, stopping once the delay is met
    always_comb begin
        cnt_d = cnt_q;
        if (!level_i) begin
            cnt_d = '0;
        end else if (cnt_q < delay_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Gated by the live input so a drop takes effect without waiting for a clock
    assign level_o = level_i && (cnt_q >= delay_i);

endmodule

// File: rtl/strobe_chk_w_delay.sv
// Strobe spacing checker: hunts, verifies and locks onto a marker-qualified strobe after a delayed online.
// Latency: outputs registered, updated 1 clk after the evaluated marker word.
// No backpressure; words without rx_marker are ignored. Optional error counter: STROBE_CHK_ERR_CNT_EN.
module strobe_chk_w_delay
    import strobe_pkg::*;
#(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 4,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [STRB_IW-1:0]   interval,
    input  logic [STRB_IW-1:0]   delay_value,
    input  logic                 online,
    input  logic                 rx_marker,
    input  logic                 rx_strobe,
    input  logic                 err_cnt_clr,
    output logic                 locked,
    output logic                 strobe_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);

    strb_state_e        state_q, state_d;
    logic [STRB_IW-1:0] wcnt_q, wcnt_d;
    logic [3:0]         good_cnt_q, good_cnt_d;
    logic [3:0]         miss_cnt_q, miss_cnt_d;
    logic               locked_q, locked_d;
    logic               strobe_err_q, strobe_err_d;

    logic               dly_on;
    logic               at_slot;
    logic [STRB_IW-1:0] wcnt_inc;

    level_delay #(
        .W (STRB_IW)
    ) u_online_dly (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (online),
        .delay_i (delay_value),
        .level_o (dly_on)
    );

    assign at_slot  = (wcnt_q == interval);
    assign wcnt_inc = (wcnt_q == {STRB_IW{1'b1}}) ? wcnt_q : wcnt_q + 1'b1;

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            good_cnt_q <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            good_cnt_q <= good_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Next state and counters; only marker words advance the check
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        good_cnt_d = good_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (!dly_on) begin
            state_d    = IDLE;
            wcnt_d     = '0;
            good_cnt_d = '0;
            miss_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wcnt_d     = '0;
                    good_cnt_d = '0;
                    miss_cnt_d = '0;
                    state_d    = HUNT;
                end
                HUNT: begin
                    good_cnt_d = '0;
                    miss_cnt_d = '0;
                    if (rx_marker) begin
                        wcnt_d = rx_strobe ? '0 : wcnt_inc;
                        if (rx_strobe) begin
                            state_d = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (rx_marker) begin
                        if (rx_strobe) begin
                            // Every strobe re-anchors here; only on-slot ones build towards lock
                            wcnt_d = '0;
                            if (at_slot) begin
                                if (good_cnt_q + 4'd1 == LOCK_C) begin
                                    state_d    = LOCKED;
                                    good_cnt_d = '0;
                                    miss_cnt_d = '0;
                                end else begin
                                    good_cnt_d = good_cnt_q + 4'd1;
                                end
                            end else begin
                                good_cnt_d = '0;
                            end
                        end else begin
                            wcnt_d = wcnt_inc;
                            if (at_slot) begin
                                state_d    = HUNT;
                                good_cnt_d = '0;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (rx_marker) begin
                        // Flywheel on the expected slot: a missing strobe keeps the cadence,
                        // an early strobe is not trusted as a new anchor
                        wcnt_d = at_slot ? '0 : wcnt_inc;
                        if (rx_strobe && at_slot) begin
                            miss_cnt_d = '0;
                        end else if (rx_strobe ^ at_slot) begin
                            if (miss_cnt_q + 4'd1 == UNLOCK_C) begin
                                state_d    = HUNT;
                                miss_cnt_d = '0;
                            end else begin
                                miss_cnt_d = miss_cnt_q + 4'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output next values: error pulses only for bad checks while locked
    always_comb begin
        strobe_err_d = dly_on && (state_q == LOCKED) && rx_marker && (rx_strobe ^ at_slot);
        locked_d     = (state_d == LOCKED);
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q     <= 1'b0;
            strobe_err_q <= 1'b0;
        end else begin
            locked_q     <= locked_d;
            strobe_err_q <= strobe_err_d;
        end
    end

    assign locked     = locked_q;
    assign strobe_err = strobe_err_q;

`ifdef STROBE_CHK_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Saturating error counter; clear beats a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (err_cnt_clr) begin
            err_cnt_q <= '0;
        end else if (strobe_err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic err_cnt_clr_unused;
    assign err_cnt_clr_unused = err_cnt_clr;
    assign err_cnt            = '0;
`endif

endmodule

// File: tb/tb_strobe_chk_w_delay.sv
// Bench for strobe_chk_w_delay: directed scenarios then random traffic against a marker-index model.
// Outputs are sampled 1 time unit after each rising edge.
// Expected error-counter values follow STROBE_CHK_ERR_CNT_EN.
module tb_strobe_chk_w_delay;

    localparam int LOCK   = 3;
    localparam int UNLOCK = 4;
    localparam int EW     = 4;
    localparam int EMAX   = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   interval = '0;
    logic [15:0]   delay_value = '0;
    logic          online = 1'b0;
    logic          rx_marker = 1'b0;
    logic          rx_strobe = 1'b0;
    logic          err_cnt_clr = 1'b0;
    logic          locked;
    logic          strobe_err;
    logic [EW-1:0] err_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int n_pulses = 0;
    int gen_pos  = 0;

    // Model: positions are absolute marker-word indices; spacing is derived from them
    int     m_mode;   // 0 idle, 1 hunt, 2 verify, 3 locked
    longint m_idx, m_anchor;
    int     m_good, m_miss, m_hi;
    bit     e_locked, e_err;
    int     e_cnt;

    strobe_chk_w_delay #(
        .LOCK_CNT   (LOCK),
        .UNLOCK_CNT (UNLOCK),
        .ERR_CNT_W  (EW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .interval    (interval),
        .delay_value (delay_value),
        .online      (online),
        .rx_marker   (rx_marker),
        .rx_strobe   (rx_strobe),
        .err_cnt_clr (err_cnt_clr),
        .locked      (locked),
        .strobe_err  (strobe_err),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_anchor = 0; m_good = 0; m_miss = 0; m_hi = 0;
        e_locked = 0; e_err = 0; e_cnt = 0;
    endtask

    task automatic model_step();
        bit     dly, on;
        longint gap;
        dly   = online && (m_hi >= int'(delay_value));
        e_err = 0;
        if (!dly) begin
            m_mode = 0; m_good = 0; m_miss = 0;
        end else begin
            gap = m_idx - m_anchor - 1;
            if (gap > 65535) gap = 65535;
            on = (gap == longint'(interval));
            case (m_mode)
                0: m_mode = 1;
                1: if (rx_marker && rx_strobe) begin
                       m_anchor = m_idx; m_good = 0; m_mode = 2;
                   end
                2: if (rx_marker) begin
                       if (rx_strobe && on) begin
                           m_anchor = m_idx; m_good++;
                           if (m_good == LOCK) begin m_mode = 3; m_miss = 0; end
                       end else if (rx_strobe) begin
                           m_anchor = m_idx; m_good = 0;
                       end else if (on) begin
                           m_mode = 1; m_good = 0;
                       end
                   end
                default: if (rx_marker) begin
                       if (on) m_anchor = m_idx;
                       if (rx_strobe && on) m_miss = 0;
                       else if (rx_strobe || on) begin
                           e_err = 1; m_miss++;
                           if (m_miss == UNLOCK) m_mode = 1;
                       end
                   end
            endcase
        end
        if (rx_marker) m_idx++;
        m_hi     = online ? ((m_hi < 65536) ? m_hi + 1 : m_hi) : 0;
        e_locked = (m_mode == 3);
`ifdef STROBE_CHK_ERR_CNT_EN
        if (err_cnt_clr) e_cnt = 0;
        else if (e_err && e_cnt < EMAX) e_cnt++;
`else
        e_cnt = 0;
`endif
    endtask

    // One clock with the given inputs; the model predicts the registered outputs
    task automatic step(input bit on, input bit mk, input bit st);
        online = on; rx_marker = mk; rx_strobe = st;
        model_step();
        @(posedge clk); #1;
        if (strobe_err === 1'b1) n_pulses++;
        chk("locked", 32'(locked), 32'(e_locked));
        chk("strobe_err", 32'(strobe_err), 32'(e_err));
        chk("err_cnt", 32'(err_cnt), 32'(e_cnt));
        err_cnt_clr = 1'b0;
    endtask

    // Marker every cycle, strobe on every (interval+1)th marker when enabled
    task automatic ideal(input int ncyc, input bit with_strobe);
        for (int i = 0; i < ncyc; i++) begin
            step(1'b1, 1'b1, with_strobe && ((gen_pos % (int'(interval) + 1)) == 0));
            gen_pos++;
        end
    endtask

    initial begin
        int p0;
        int exp_cnt;
        model_reset();
        #12;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_strobe_err", 32'(strobe_err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: interval 9, delay 20, ideal strobes
        interval = 16'd9; delay_value = 16'd20; gen_pos = 3;
        p0 = n_pulses;
        ideal(80, 1'b1);
        chk("t1_locked", 32'(locked), 32'd1);
        chk("t1_no_err", 32'(n_pulses - p0), 32'd0);

        // 2: interval 0, strobe every marker, then one drop
        err_cnt_clr = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        interval = 16'd0; delay_value = 16'd0;
        ideal(5, 1'b1);
        chk("t2_locked_4", 32'(locked), 32'd1);
        p0 = n_pulses;
        step(1'b1, 1'b1, 1'b0);
        chk("t2_one_pulse", 32'(n_pulses - p0), 32'd1);
`ifdef STROBE_CHK_ERR_CNT_EN
        exp_cnt = 1;
`else
        exp_cnt = 0;
`endif
        chk("t2_err_cnt", 32'(err_cnt), 32'(exp_cnt));
        chk("t2_still_locked", 32'(locked), 32'd1);
        ideal(3, 1'b1);

        // 3: interval 4, lose strobes for 4 intervals, then recover
        step(1'b0, 1'b0, 1'b0);
        interval = 16'd4; gen_pos = 0;
        ideal(40, 1'b1);
        chk("t3_locked", 32'(locked), 32'd1);
        p0 = n_pulses;
        ideal(20, 1'b0);
        chk("t3_four_pulses", 32'(n_pulses - p0), 32'd4);
        chk("t3_unlocked", 32'(locked), 32'd0);
        ideal(40, 1'b1);
        chk("t3_relocked", 32'(locked), 32'd1);

        // 4: strobes only on non-marker words
        err_cnt_clr = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) step(1'b1, i[0], ~i[0]);
        chk("t4_locked", 32'(locked), 32'd0);
        chk("t4_err_cnt", 32'(err_cnt), 32'd0);

        // 5: drop online while locked, rejoin with delay 5
        gen_pos = 0;
        ideal(40, 1'b1);
        chk("t5_locked", 32'(locked), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        chk("t5_drop", 32'(locked), 32'd0);
        delay_value = 16'd5; gen_pos = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1);
            chk("t5_wait", 32'(locked), 32'd0);
        end
        interval = 16'd0;
        ideal(10, 1'b1);
        chk("t5_relock", 32'(locked), 32'd1);

        // 6: saturation and clear-beats-increment
        err_cnt_clr = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        delay_value = 16'd0;
        ideal(8, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b1);
        end
`ifdef STROBE_CHK_ERR_CNT_EN
        exp_cnt = EMAX;
`else
        exp_cnt = 0;
`endif
        chk("t6_saturated", 32'(err_cnt), 32'(exp_cnt));
        chk("t6_locked", 32'(locked), 32'd1);
        err_cnt_clr = 1'b1;
        p0 = n_pulses;
        step(1'b1, 1'b1, 1'b0);
        chk("t6_clr_pulse", 32'(n_pulses - p0), 32'd1);
        chk("t6_clr_wins", 32'(err_cnt), 32'd0);
        ideal(4, 1'b1);

        // Asynchronous reset mid-operation
        rst_n = 1'b0; #1;
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_err_cnt", 32'(err_cnt), 32'd0);
        model_reset();
        @(posedge clk); #2; rst_n = 1'b1;
        @(posedge clk); #1;
        err_cnt_clr = 1'b0;

        // Random traffic
        interval = 16'd3; gen_pos = 0;
        for (int i = 0; i < 3000; i++) begin
            bit on, mk, st;
            on = 1'b1;
            if ($urandom_range(299, 0) == 0) begin
                for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
                interval    = 16'($urandom_range(7, 0));
                delay_value = 16'($urandom_range(10, 0));
            end
            if ($urandom_range(599, 0) == 0) interval = 16'($urandom_range(7, 0));
            if ($urandom_range(99, 0) == 0) err_cnt_clr = 1'b1;
            mk = ($urandom_range(99, 0) < 80);
            st = ($urandom_range(99, 0) < 95) && ((gen_pos % (int'(interval) + 1)) == 0);
            if ($urandom_range(99, 0) < 3) st = ~st;
            if (!mk && $urandom_range(1, 0) == 1) st = 1'b1;
            step(on, mk, st);
            if (mk) gen_pos++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
